// File: rtl/handshake_fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module   : handshake_fifo_buffer
// Function : Elastic FIFO for valid/ready dataflow channels; optional
//            transparent bypass mode enabled by HANDSHAKE_FIFO_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module handshake_fifo_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SLOTS  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] ins,
   input  logic                  ins_valid,
   output logic                  ins_ready,
   output logic [DATA_WIDTH-1:0] outs,
   output logic                  outs_valid,
   input  logic                  outs_ready
);

   localparam int c_PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int c_CNT_W = $clog2(NUM_SLOTS + 1);
   localparam logic [c_PTR_W-1:0] c_LAST_SLOT = c_PTR_W'(NUM_SLOTS - 1);
   localparam logic [c_CNT_W-1:0] c_FULL_CNT  = c_CNT_W'(NUM_SLOTS);

   logic [DATA_WIDTH-1:0] r_mem [NUM_SLOTS];
   logic [c_PTR_W-1:0]    r_head;
   logic [c_PTR_W-1:0]    r_tail;
   logic [c_CNT_W-1:0]    r_count;

   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_store;
   logic w_pop;

   function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] ptr);
      return (ptr == c_LAST_SLOT) ? '0 : ptr + 1'b1;
   endfunction

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_FULL_CNT);
   assign w_push  = ins_valid && ins_ready;
   // Storage only ever pops a stored token; a bypassed token never occupies a slot.
   assign w_pop   = !w_empty && outs_ready;

`ifdef HANDSHAKE_FIFO_BYPASS_EN
   assign ins_ready  = rst || !w_full || outs_ready;
   assign outs_valid = !rst && (!w_empty || ins_valid);
   assign outs       = rst ? '0 : (w_empty ? ins : r_mem[r_head]);
   assign w_store    = w_push && !(w_empty && outs_ready);
`else
   // Outputs come straight from state, so no ins_* -> outs_* or outs_ready -> ins_ready path.
   assign ins_ready  = rst || !w_full;
   assign outs_valid = !rst && !w_empty;
   assign outs       = rst ? '0 : r_mem[r_head];
   assign w_store    = w_push;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_store) begin
            r_mem[r_tail] <= ins;
            r_tail        <= f_next_ptr(r_tail);
         end
         if (w_pop) begin
            r_head <= f_next_ptr(r_head);
         end
         if (w_store && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_store) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_handshake_fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_handshake_fifo_buffer
// Function : Self-checking bench for handshake_fifo_buffer against a queue
//            model; follows HANDSHAKE_FIFO_BYPASS_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_handshake_fifo_buffer;

   localparam int c_DW = 16;
   localparam int c_NS = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [c_DW-1:0] ins = '0;
   logic            ins_valid = 1'b0;
   logic            ins_ready;
   logic [c_DW-1:0] outs;
   logic            outs_valid;
   logic            outs_ready = 1'b0;

   always #5 clk = ~clk;

   handshake_fifo_buffer #(
      .DATA_WIDTH (c_DW),
      .NUM_SLOTS  (c_NS)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .ins        (ins),
      .ins_valid  (ins_valid),
      .ins_ready  (ins_ready),
      .outs       (outs),
      .outs_valid (outs_valid),
      .outs_ready (outs_ready)
   );

   int              n_vec = 0;
   int              n_err = 0;
   logic [c_DW-1:0] r_q[$];
   bit              r_fresh = 1'b1;
   logic [c_DW-1:0] r_seq = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive, compare against the model, then advance the model.
   task automatic cycle(input logic r, input logic iv, input logic [c_DW-1:0] d,
                        input logic ordy, output bit acc);
      logic            e_rdy;
      logic            e_vld;
      logic [c_DW-1:0] e_dat;
      bit              was_empty;
      bit              do_push;
      bit              do_pop;
      @(negedge clk);
      rst = r; ins_valid = iv; ins = d; outs_ready = ordy;
      #1;
      was_empty = (r_q.size() == 0);
      if (r) begin
         e_rdy = 1'b1; e_vld = 1'b0;
      end else begin
`ifdef HANDSHAKE_FIFO_BYPASS_EN
         e_rdy = (r_q.size() < c_NS) || ordy;
         e_vld = !was_empty || iv;
`else
         e_rdy = (r_q.size() < c_NS);
         e_vld = !was_empty;
`endif
      end
      if (!e_vld)         e_dat = '0;
      else if (was_empty) e_dat = d;
      else                e_dat = r_q[0];
      check_eq("ins_ready", 32'(ins_ready), 32'(e_rdy));
      check_eq("outs_valid", 32'(outs_valid), 32'(e_vld));
      if (e_vld || r || r_fresh) check_eq("outs", 32'(outs), 32'(e_dat));
      do_push = !r && iv && e_rdy;
      do_pop  = !r && e_vld && ordy;
      acc = do_push;
      @(posedge clk);
      if (r) begin
         r_q.delete();
         r_fresh = 1'b1;
      end else if (!was_empty) begin
         if (do_pop)  void'(r_q.pop_front());
         if (do_push) begin r_q.push_back(d); r_fresh = 1'b0; end
      end else if (do_push && !do_pop) begin
         r_q.push_back(d);
         r_fresh = 1'b0;
      end
   endtask

   // pat 0: outs_ready toggles 1,0,...; pat 1: random ready and occasional reset.
   task automatic stream(input int ncyc, input int pat);
      bit              acc;
      logic            iv = 1'b0;
      logic [c_DW-1:0] d = '0;
      logic            r;
      logic            ordy;
      for (int c = 0; c < ncyc; c++) begin
         if (!iv) begin
            iv = (pat == 0) ? 1'b1 : ($urandom_range(0, 99) < 60);
            d  = r_seq;
         end
         ordy = (pat == 0) ? (c % 2 == 0) : ($urandom_range(0, 99) < 55);
         r    = (pat == 1) && ($urandom_range(0, 99) == 0);
         cycle(r, iv, d, ordy, acc);
         if (acc || r) begin
            iv = 1'b0;
            if (acc) r_seq = r_seq + 1'b1;
         end
      end
   endtask

   initial begin
      bit acc;
      cycle(1'b1, 1'b0, '0, 1'b0, acc);
      cycle(1'b1, 1'b1, 16'h1234, 1'b1, acc);

      // single token
      cycle(1'b0, 1'b1, 16'h03E8, 1'b1, acc);
      cycle(1'b0, 1'b0, '0, 1'b1, acc);
      cycle(1'b0, 1'b0, '0, 1'b1, acc);

      // fill, stall, drain
      for (int i = 1; i <= c_NS + 1; i++) cycle(1'b0, 1'b1, 16'(i), 1'b0, acc);
      cycle(1'b0, 1'b1, 16'(c_NS + 1), 1'b0, acc);
      for (int i = 0; i < c_NS + 3; i++) cycle(1'b0, !acc, 16'(c_NS + 1), 1'b1, acc);

      // simultaneous push and pop at count 2
      cycle(1'b0, 1'b1, 16'h0001, 1'b0, acc);
      cycle(1'b0, 1'b1, 16'h0002, 1'b0, acc);
      cycle(1'b0, 1'b1, 16'h000A, 1'b1, acc);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1, acc);

      // reset mid-operation with a push and pop active
      for (int i = 0; i < c_NS; i++) cycle(1'b0, 1'b1, 16'h0B00 + 16'(i), 1'b0, acc);
      cycle(1'b1, 1'b1, 16'h0BFF, 1'b1, acc);
      cycle(1'b0, 1'b0, '0, 1'b1, acc);
      cycle(1'b0, 1'b0, '0, 1'b1, acc);

      // wrap-around stream, then randomized traffic
      r_seq = '0;
      stream(24, 0);
      stream(3000, 1);
      for (int i = 0; i < c_NS + 2; i++) cycle(1'b0, 1'b0, '0, 1'b1, acc);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
